// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_pkg
// Purpose  : Shared types, field constants and condition evaluation for arm.
// Revision : 1.0
// ============================================================================
package arm_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam logic [1:0] c_op_dp  = 2'b00;
    localparam logic [1:0] c_op_mem = 2'b01;
    localparam logic [1:0] c_op_br  = 2'b10;

    localparam logic [3:0] c_dp_add = 4'b0100;
    localparam logic [3:0] c_dp_sub = 4'b0010;
    localparam logic [3:0] c_dp_and = 4'b0000;
    localparam logic [3:0] c_dp_orr = 4'b1100;

    localparam logic [3:0] c_reg_pc = 4'd15;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_ORR = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM8  = 2'd0,
        IMM12 = 2'd1,
        IMM24 = 2'd2
    } imm_src_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    function automatic logic cond_holds(input cond_e cond, input flags_t f);
        logic ok;
        case (cond)
            COND_EQ: ok = f.z;
            COND_NE: ok = !f.z;
            COND_CS: ok = f.c;
            COND_CC: ok = !f.c;
            COND_MI: ok = f.n;
            COND_PL: ok = !f.n;
            COND_VS: ok = f.v;
            COND_VC: ok = !f.v;
            COND_HI: ok = f.c && !f.z;
            COND_LS: ok = !f.c || f.z;
            COND_GE: ok = (f.n == f.v);
            COND_LT: ok = (f.n != f.v);
            COND_GT: ok = !f.z && (f.n == f.v);
            COND_LE: ok = f.z || (f.n != f.v);
            COND_AL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arm_if.sv
`default_nettype none
// ============================================================================
// Module   : arm_if
// Purpose  : Core-side bundle to instruction and data memories.
// Revision : 1.0
// ============================================================================
interface arm_if;
    logic [31:0] PC;
    logic [31:0] Instr;
    logic        MemWrite;
    logic        MemByte;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output PC, MemWrite, MemByte, ALUResult, WriteData,
        input  Instr, ReadData
    );

    modport slave (
        input  PC, MemWrite, MemByte, ALUResult, WriteData,
        output Instr, ReadData
    );
endinterface
`default_nettype wire

// File: rtl/arm_regfile.sv
`default_nettype none
// ============================================================================
// Module   : arm_regfile
// Purpose  : R0-R14 storage, two combinational reads, one clocked write.
// Revision : 1.0
// ============================================================================
module arm_regfile
    import arm_pkg::*;
(
    input  wire         clk,
    input  wire         reset,
    input  wire  [3:0]  ra1,
    input  wire  [3:0]  ra2,
    input  wire         we3,
    input  wire  [3:0]  wa3,
    input  wire  [31:0] wd3,
    input  wire  [31:0] r15,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] r_regs [0:14];

    // R15 lives in the PC register of the core; writes to it are dropped here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we3 && (wa3 != c_reg_pc)) begin
            r_regs[wa3] <= wd3;
        end
    end

    assign rd1 = (ra1 == c_reg_pc) ? r15 : r_regs[ra1];
    assign rd2 = (ra2 == c_reg_pc) ? r15 : r_regs[ra2];

endmodule
`default_nettype wire

// File: rtl/arm.sv
`default_nettype none
// ============================================================================
// Module   : arm
// Purpose  : Single-cycle ARMv4-subset core: DP, LDR/STR(B), B, full conditions.
// Revision : 1.0
// ============================================================================
module arm
    import arm_pkg::*;
(
    input  wire   clk,
    input  wire   reset,
    arm_if.master bus
);
    logic [31:0] r_pc;
    flags_t      r_flags;

    logic [31:0] w_instr;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_plus8;
    logic [1:0]  w_op;
    logic [3:0]  w_rn;
    logic [3:0]  w_rd;
    logic [3:0]  w_rm;
    logic [3:0]  w_cmd;
    logic        w_cond_ok;
    logic        w_is_dp;
    logic        w_is_mem;
    logic        w_is_br;
    logic        w_load;
    logic        w_store;
    logic        w_dp_valid;
    alu_op_e     w_alu_op;
    imm_src_e    w_imm_src;
    logic [3:0]  w_ra1;
    logic [3:0]  w_ra2;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;
    logic [31:0] w_ext;
    logic [31:0] w_src_b;
    logic [31:0] w_src_b_eff;
    logic [32:0] w_sum;
    logic [31:0] w_alu_result;
    logic        w_arith;
    logic        w_carry;
    logic        w_overflow;
    logic [31:0] w_load_data;
    logic [31:0] w_result;
    logic        w_reg_write;
    logic        w_pc_write;
    logic        w_flag_write;
    flags_t      w_flags_next;
    logic [31:0] w_pc_next;

    assign w_instr    = bus.Instr;
    assign w_op       = w_instr[27:26];
    assign w_rn       = w_instr[19:16];
    assign w_rd       = w_instr[15:12];
    assign w_rm       = w_instr[3:0];
    assign w_cmd      = w_instr[24:21];
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_plus8 = r_pc + 32'd8;

    assign w_cond_ok = cond_holds(cond_e'(w_instr[31:28]), r_flags);
    assign w_is_dp   = (w_op == c_op_dp);
    assign w_is_mem  = (w_op == c_op_mem);
    assign w_is_br   = (w_op == c_op_br) && !w_instr[24];
    assign w_load    = w_is_mem && w_instr[20];
    assign w_store   = w_is_mem && !w_instr[20];

    always_comb begin
        w_dp_valid = 1'b0;
        w_alu_op   = ALU_ADD;
        w_imm_src  = IMM8;
        if (w_is_dp) begin
            w_imm_src = IMM8;
            case (w_cmd)
                c_dp_add: begin w_alu_op = ALU_ADD; w_dp_valid = 1'b1; end
                c_dp_sub: begin w_alu_op = ALU_SUB; w_dp_valid = 1'b1; end
                c_dp_and: begin w_alu_op = ALU_AND; w_dp_valid = 1'b1; end
                c_dp_orr: begin w_alu_op = ALU_ORR; w_dp_valid = 1'b1; end
                default:  w_dp_valid = 1'b0;
            endcase
        end else if (w_is_mem) begin
            w_imm_src = IMM12;
            w_alu_op  = w_instr[23] ? ALU_ADD : ALU_SUB;
        end else if (w_is_br) begin
            w_imm_src = IMM24;
            w_alu_op  = ALU_ADD;
        end
    end

    // The 8-bit immediate is taken unrotated; the rotate field is ignored.
    always_comb begin
        case (w_imm_src)
            IMM8:    w_ext = {24'd0, w_instr[7:0]};
            IMM12:   w_ext = {20'd0, w_instr[11:0]};
            IMM24:   w_ext = {{6{w_instr[23]}}, w_instr[23:0], 2'b00};
            default: w_ext = '0;
        endcase
    end

    assign w_ra1   = w_is_br ? c_reg_pc : w_rn;
    assign w_ra2   = w_store ? w_rd : w_rm;
    assign w_src_b = (w_is_dp && !w_instr[25]) ? w_rd2 : w_ext;

    arm_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (w_ra1),
        .ra2   (w_ra2),
        .we3   (w_reg_write),
        .wa3   (w_rd),
        .wd3   (w_result),
        .r15   (w_pc_plus8),
        .rd1   (w_rd1),
        .rd2   (w_rd2)
    );

    // Subtract as A + ~B + 1 so the adder carry-out is ARM's NOT-borrow.
    assign w_src_b_eff = (w_alu_op == ALU_SUB) ? ~w_src_b : w_src_b;
    assign w_sum       = {1'b0, w_rd1} + {1'b0, w_src_b_eff}
                       + {32'd0, (w_alu_op == ALU_SUB)};

    always_comb begin
        case (w_alu_op)
            ALU_AND: w_alu_result = w_rd1 & w_src_b;
            ALU_ORR: w_alu_result = w_rd1 | w_src_b;
            default: w_alu_result = w_sum[31:0];
        endcase
    end

    assign w_arith    = (w_alu_op == ALU_ADD) || (w_alu_op == ALU_SUB);
    assign w_carry    = w_sum[32];
    assign w_overflow = (w_rd1[31] == w_src_b_eff[31]) && (w_sum[31] != w_rd1[31]);

    assign w_load_data = w_instr[22] ? {24'd0, bus.ReadData[7:0]} : bus.ReadData;
    assign w_result    = w_load ? w_load_data : w_alu_result;

    assign w_reg_write  = w_cond_ok && (w_dp_valid || w_load);
    assign w_pc_write   = w_reg_write && (w_rd == c_reg_pc);
    assign w_flag_write = w_cond_ok && w_dp_valid && w_instr[20];

    always_comb begin
        w_flags_next.n = w_alu_result[31];
        w_flags_next.z = (w_alu_result == 32'd0);
        w_flags_next.c = w_arith ? w_carry : r_flags.c;
        w_flags_next.v = w_arith ? w_overflow : r_flags.v;
    end

    always_comb begin
        if (w_cond_ok && w_is_br) begin
            w_pc_next = w_alu_result;
        end else if (w_pc_write) begin
            w_pc_next = w_result;
        end else begin
            w_pc_next = w_pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= '0;
            r_flags <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (w_flag_write) begin
                r_flags <= w_flags_next;
            end
        end
    end

    assign bus.PC        = r_pc;
    assign bus.MemWrite  = reset && w_cond_ok && w_store;
    assign bus.MemByte   = ~w_instr[22];
    assign bus.ALUResult = w_alu_result;
    assign bus.WriteData = w_rd2;

endmodule
`default_nettype wire

// File: tb/tb_arm.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm
// Purpose  : Directed and random instruction streams against an ISA-level model.
// Revision : 1.0
// ============================================================================
module tb_arm;
    localparam logic [31:0] c_nop = 32'hE1A00000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_if bus();

    arm u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Environment data memory: byte array, little-endian, address wraps at 256.
    logic [7:0] e_mem [0:255];
    logic [7:0] e_a;
    assign e_a = bus.ALUResult[7:0];
    assign bus.ReadData = {e_mem[e_a + 8'd3], e_mem[e_a + 8'd2], e_mem[e_a + 8'd1], e_mem[e_a]};

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) e_mem[i] <= init_byte(i);
        end else if (bus.MemWrite) begin
            e_mem[e_a] <= bus.WriteData[7:0];
            if (bus.MemByte) begin
                e_mem[e_a + 8'd1] <= bus.WriteData[15:8];
                e_mem[e_a + 8'd2] <= bus.WriteData[23:16];
                e_mem[e_a + 8'd3] <= bus.WriteData[31:24];
            end
        end
    end

    // Architectural reference model.
    logic [31:0] m_regs [0:14];
    logic [31:0] m_pc;
    logic        m_n, m_z, m_c, m_v;
    logic [7:0]  m_mem [0:255];

    logic [31:0] x_pc, x_addr, x_wdata;
    logic        x_mw, x_mem, x_mb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = '0;
        m_pc = '0;
        {m_n, m_z, m_c, m_v} = 4'b0000;
    endtask

    function automatic logic [31:0] rv(input logic [3:0] r);
        return (r == 4'd15) ? m_pc + 32'd8 : m_regs[r];
    endfunction

    function automatic logic cond_pass(input logic [3:0] c);
        case (c)
            4'h0: return m_z;
            4'h1: return !m_z;
            4'h2: return m_c;
            4'h3: return !m_c;
            4'h4: return m_n;
            4'h5: return !m_n;
            4'h6: return m_v;
            4'h7: return !m_v;
            4'h8: return m_c && !m_z;
            4'h9: return !m_c || m_z;
            4'hA: return m_n == m_v;
            4'hB: return m_n != m_v;
            4'hC: return !m_z && (m_n == m_v);
            4'hD: return m_z || (m_n != m_v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input logic [31:0] ins);
        logic        ok, valid, is_add, is_sub;
        logic [31:0] a, b, res, nxt;
        logic [3:0]  rd;
        logic [7:0]  ad;
        longint      sres;
        ok = cond_pass(ins[31:28]);
        rd = ins[15:12];
        x_pc = m_pc; x_mw = 1'b0; x_mem = 1'b0; x_mb = 1'b0; x_addr = '0; x_wdata = '0;
        nxt = m_pc + 32'd4;
        case (ins[27:26])
            2'b00: begin
                a = rv(ins[19:16]);
                b = ins[25] ? {24'd0, ins[7:0]} : rv(ins[3:0]);
                is_add = (ins[24:21] == 4'b0100);
                is_sub = (ins[24:21] == 4'b0010);
                valid = 1'b1; sres = 0; res = '0;
                if (is_add) begin
                    res = a + b; sres = longint'($signed(a)) + longint'($signed(b));
                end else if (is_sub) begin
                    res = a - b; sres = longint'($signed(a)) - longint'($signed(b));
                end else if (ins[24:21] == 4'b0000) res = a & b;
                else if (ins[24:21] == 4'b1100) res = a | b;
                else valid = 1'b0;
                if (ok && valid) begin
                    if (ins[20]) begin
                        m_n = res[31];
                        m_z = (res == 32'd0);
                        if (is_add) m_c = ((64'(a) + 64'(b)) > 64'hFFFF_FFFF);
                        if (is_sub) m_c = (a >= b);
                        if (is_add || is_sub) m_v = (longint'($signed(res)) != sres);
                    end
                    if (rd == 4'd15) nxt = res; else m_regs[rd] = res;
                end
            end
            2'b01: begin
                a = rv(ins[19:16]);
                res = ins[23] ? a + {20'd0, ins[11:0]} : a - {20'd0, ins[11:0]};
                x_mem = 1'b1; x_addr = res; x_mb = !ins[22]; ad = res[7:0];
                if (ins[20]) begin
                    b = ins[22] ? {24'd0, m_mem[ad]}
                                : {m_mem[ad + 8'd3], m_mem[ad + 8'd2], m_mem[ad + 8'd1], m_mem[ad]};
                    if (ok) begin
                        if (rd == 4'd15) nxt = b; else m_regs[rd] = b;
                    end
                end else if (ok) begin
                    x_mw = 1'b1;
                    x_wdata = rv(rd);
                    m_mem[ad] = x_wdata[7:0];
                    if (!ins[22]) begin
                        m_mem[ad + 8'd1] = x_wdata[15:8];
                        m_mem[ad + 8'd2] = x_wdata[23:16];
                        m_mem[ad + 8'd3] = x_wdata[31:24];
                    end
                end
            end
            2'b10: begin
                if (!ins[24] && ok) nxt = m_pc + 32'd8 + ({{8{ins[23]}}, ins[23:0]} << 2);
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic issue(input logic [31:0] ins);
        bus.Instr = ins;
        model_step(ins);
        @(negedge clk);
        check("pc", bus.PC, x_pc);
        check("memwrite", 32'(bus.MemWrite), 32'(x_mw));
        if (x_mem) begin
            check("alu_result", bus.ALUResult, x_addr);
            check("membyte", 32'(bus.MemByte), 32'(x_mb));
        end
        if (x_mw) check("write_data", bus.WriteData, x_wdata);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] ins);
        issue(ins);
        advance();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0] cond, rd, rn, cmd;
        int k;
        k    = int'($urandom_range(0, 99));
        cond = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
        rd   = ($urandom_range(0, 31) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
        rn   = 4'($urandom_range(0, 15));
        case (int'($urandom_range(0, 4)))
            0:       cmd = 4'b0100;
            1:       cmd = 4'b0010;
            2:       cmd = 4'b0000;
            3:       cmd = 4'b1100;
            default: cmd = 4'($urandom());
        endcase
        if (k < 45) begin
            if ($urandom_range(0, 1) == 1)
                return {cond, 3'b001, cmd, 1'($urandom()), rn, rd, 4'($urandom()), 8'($urandom())};
            return {cond, 3'b000, cmd, 1'($urandom()), rn, rd, 8'd0, 4'($urandom_range(0, 15))};
        end
        if (k < 80)
            return {cond, 3'b010, 1'b1, 1'($urandom()), 1'($urandom()), 1'b0, 1'($urandom()),
                    rn, rd, 12'($urandom())};
        if (k < 95)
            return {cond, 3'b101, ($urandom_range(0, 5) == 0), 24'(int'($urandom_range(0, 63)) - 32)};
        return {cond, 2'b11, 26'($urandom())};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = init_byte(i);
        model_reset();
        reset     = 1'b0;
        bus.Instr = 32'hE5837064;
        repeat (2) begin
            @(negedge clk);
            check("reset_pc", bus.PC, 32'd0);
            check("reset_memwrite", 32'(bus.MemWrite), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            issue(c_nop);
            check("pc_after_reset", bus.PC, 32'(4 * i));
            advance();
        end
        for (int i = 0; i < 16 && m_pc != 32'h20; i++) step(c_nop);

        issue(32'hEA000001); check("branch_fwd_pc", bus.PC, 32'h20); advance();
        issue(32'hEAFFFFFE); check("branch_target", bus.PC, 32'h2C); advance();
        issue(c_nop);        check("branch_self", bus.PC, 32'h2C);   advance();

        step(32'hE04F000F);
        step(32'hE2802005);
        step(32'hE1823000);
        issue(32'hE5803000); check("orr_r3", bus.WriteData, 32'd5); advance();
        step(32'hE2527005);
        step(32'h12808001);
        issue(32'hE5808004); check("addne_skipped", bus.WriteData, 32'd0); advance();
        step(32'h02808001);
        issue(32'hE5808004); check("addeq_taken", bus.WriteData, 32'd1); advance();
        step(32'h2280A003);
        issue(32'hE580A008); check("addcs_taken", bus.WriteData, 32'd3); advance();
        step(32'hE0433003);
        step(32'hE28270F9);
        issue(32'hE5837064);
        check("str_memwrite", 32'(bus.MemWrite), 32'd1);
        check("str_addr", bus.ALUResult, 32'd100);
        check("str_data", bus.WriteData, 32'd254);
        check("str_membyte", 32'(bus.MemByte), 32'd1);
        advance();
        step(32'hE5939064);
        issue(32'hE5839060);
        check("ldr_value", bus.WriteData, 32'd254);
        check("str96_addr", bus.ALUResult, 32'd96);
        advance();
        issue(32'hE5C37065); check("strb_membyte", 32'(bus.MemByte), 32'd0); advance();
        step(32'hE5D3B064);
        issue(32'hE583B06C); check("ldrb_value", bus.WriteData, 32'd254); advance();
        issue(32'hF5837064); check("never_memwrite", 32'(bus.MemWrite), 32'd0); advance();

        for (int n = 0; n < 600; n++) step(rand_instr());

        // Expose every register through a store so the model can compare it.
        for (int r = 0; r < 15; r++) step({4'hE, 8'h58, 4'd0, 4'(r), 12'd200});

        bus.Instr = 32'hE5837064;
        reset = 1'b0;
        #1;
        check("async_reset_pc", bus.PC, 32'd0);
        check("async_reset_memwrite", 32'(bus.MemWrite), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
